// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register with valid/ready handshake, flush and a saturating stall counter.
// Define EX_MEM_SKID_EN to add a one-entry skid buffer behind a registered in_ready.
module ex_mem_stage #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5,
  parameter int CTRL_W = 11,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] alu_result_in,
  input  logic [DATA_W-1:0] read_data2_in,
  input  logic [REG_W-1:0]  regdst_in,
  input  logic [CTRL_W-1:0] ctrl_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] alu_result_out,
  output logic [DATA_W-1:0] read_data2_out,
  output logic [REG_W-1:0]  regdst_out,
  output logic [CTRL_W-1:0] ctrl_out,
  output logic [CNT_W-1:0]  stall_cnt
);

  typedef struct packed {
    logic [DATA_W-1:0] alu;
    logic [DATA_W-1:0] rd2;
    logic [REG_W-1:0]  rd;
    logic [CTRL_W-1:0] ctrl;
  } beat_t;

  beat_t in_beat, main_q;
  logic  main_vld;
  logic  acc, pop;

  assign in_beat = '{alu: alu_result_in, rd2: read_data2_in, rd: regdst_in, ctrl: ctrl_in};
  assign acc     = in_valid && in_ready;
  assign pop     = main_vld && out_ready;

  // Counts every edge the held beat is refused, flush edges included.
  always_ff @(negedge clk) begin
    if (reset)
      stall_cnt <= '0;
    else if (main_vld && !out_ready && stall_cnt != {CNT_W{1'b1}})
      stall_cnt <= stall_cnt + 1'b1;
  end

`ifdef EX_MEM_SKID_EN
  beat_t skid_q;
  logic  skid_vld;
  logic  rdy_q;

  always_ff @(negedge clk) begin
    if (reset) begin
      main_vld <= 1'b0;
      main_q   <= '0;
      skid_vld <= 1'b0;
      skid_q   <= '0;
      rdy_q    <= 1'b1;
    end else if (flush) begin
      main_vld    <= 1'b0;
      main_q.ctrl <= '0;
      skid_vld    <= 1'b0;
      skid_q.ctrl <= '0;
      rdy_q       <= 1'b1;
    end else if (pop) begin
      if (skid_vld) begin
        // Skid entry is older than anything on the input, so it goes first.
        main_q   <= skid_q;
        skid_vld <= 1'b0;
        rdy_q    <= 1'b1;
      end else if (acc) begin
        main_q <= in_beat;
      end else begin
        main_vld    <= 1'b0;
        main_q.ctrl <= '0;
      end
    end else if (acc) begin
      if (main_vld) begin
        skid_q   <= in_beat;
        skid_vld <= 1'b1;
        rdy_q    <= 1'b0;
      end else begin
        main_q   <= in_beat;
        main_vld <= 1'b1;
      end
    end
  end

  assign in_ready = rdy_q && !flush && !reset;
`else
  always_ff @(negedge clk) begin
    if (reset) begin
      main_vld <= 1'b0;
      main_q   <= '0;
    end else if (flush) begin
      main_vld    <= 1'b0;
      main_q.ctrl <= '0;
    end else if (acc) begin
      main_vld <= 1'b1;
      main_q   <= in_beat;
    end else if (pop) begin
      main_vld    <= 1'b0;
      main_q.ctrl <= '0;
    end
  end

  assign in_ready = !flush && !reset && (!main_vld || out_ready);
`endif

  assign out_valid      = main_vld;
  assign alu_result_out = main_q.alu;
  assign read_data2_out = main_q.rd2;
  assign regdst_out     = main_q.rd;
  assign ctrl_out       = main_q.ctrl;

endmodule
